// File: rtl/id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared definitions for the ID/EX pipeline register of the 5-stage MIPS32
// core: default widths, ALU operation codes, the hard-wired zero register
// address and the update-select encoding used by the register bank.
// ---------------------------------------------------------------------------
package id_ex_stage_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 5;
  localparam int ALUOP_W_DEF = 4;

  // Register $0 is hard-wired to zero, so it can never carry a hazard.
  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_OR  = 4'h1;
  localparam logic [3:0] ALU_ADD = 4'h2;
  localparam logic [3:0] ALU_SUB = 4'h6;
  localparam logic [3:0] ALU_SLT = 4'h7;
  localparam logic [3:0] ALU_NOR = 4'hC;

  // What the ID/EX register does on the next rising edge.
  typedef enum logic [1:0] {
    SEL_LOAD   = 2'd0,  // capture the ID instruction
    SEL_FLUSH  = 2'd1,  // squash: load a bubble
    SEL_HOLD   = 2'd2,  // freeze everything
    SEL_BUBBLE = 2'd3   // load-use: load a bubble, ID is re-presented
  } sel_e;

  // Fixed priority: flush > hold > load_use > normal load.
  function automatic sel_e pick_sel(input logic flush, input logic hold,
                                    input logic load_use);
    if (flush)         return SEL_FLUSH;
    else if (hold)     return SEL_HOLD;
    else if (load_use) return SEL_BUBBLE;
    else               return SEL_LOAD;
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// ---------------------------------------------------------------------------
// id_ex_stage_hazard_detect
// Purely combinational load-use detector. A load sitting in EX whose
// destination (rt) is read by the instruction in ID cannot be covered by
// forwarding, because the data only exists after MEM.
// Ports:
//   ex_valid_i, ex_mem_read_i, ex_rt_i : registered EX-stage state
//   id_valid_i, id_rs_i, id_rt_i       : instruction currently in ID
//   load_use_o                         : hazard present this cycle
// ---------------------------------------------------------------------------
module id_ex_stage_hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic [ADDR_W-1:0] ex_rt_i,
  input  logic              id_valid_i,
  input  logic [ADDR_W-1:0] id_rs_i,
  input  logic [ADDR_W-1:0] id_rt_i,
  output logic              load_use_o
);

  logic rt_nonzero;
  logic rt_matches;

  assign rt_nonzero = (ex_rt_i != ADDR_W'(REG_ZERO));
  assign rt_matches = (ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i);
  assign load_use_o = ex_valid_i & ex_mem_read_i & id_valid_i & rt_nonzero & rt_matches;

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with built-in load-use hazard detection.
// Captures operands, register addresses and decoded control from ID and
// presents them to EX one cycle later. On a load-use hazard a single bubble
// is inserted and stall is raised so PC and IF/ID hold the consumer.
//
// Optional feature macro: ID_EX_PERF_EN adds bubble_cnt / flush_cnt outputs.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   id_*                instruction fields from the decode stage
//   flush               squash the ID instruction (load bubble)
//   hold                freeze the whole register
//   stall               load-use hazard: hold PC and IF/ID this cycle
//   ex_valid, ex_*      registered copies of the id_* fields
//   bubble_cnt          (ID_EX_PERF_EN) edges that inserted a load-use bubble
//   flush_cnt           (ID_EX_PERF_EN) edges that took a flush
// ---------------------------------------------------------------------------
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int ALUOP_W = ALUOP_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [DATA_W-1:0]  id_pc_plus4,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [ADDR_W-1:0]  id_rs,
  input  logic [ADDR_W-1:0]  id_rt,
  input  logic [ADDR_W-1:0]  id_rd,
  input  logic               id_reg_write,
  input  logic               id_mem_to_reg,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_alu_src,
  input  logic               id_reg_dst,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic               flush,
  input  logic               hold,
  output logic               stall,
  output logic               ex_valid,
  output logic [DATA_W-1:0]  ex_pc_plus4,
  output logic [DATA_W-1:0]  ex_rs_data,
  output logic [DATA_W-1:0]  ex_rt_data,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [ADDR_W-1:0]  ex_rs,
  output logic [ADDR_W-1:0]  ex_rt,
  output logic [ADDR_W-1:0]  ex_rd,
  output logic               ex_reg_write,
  output logic               ex_mem_to_reg,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_alu_src,
  output logic               ex_reg_dst,
  output logic [ALUOP_W-1:0] ex_alu_op
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]        bubble_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  // Whole stage kept as one flat vector: a bubble is then simply all-zero,
  // which also zeroes rs/rt/rd so forwarding sees register 0 and ignores it.
  localparam int EX_W = 1 + 4 * DATA_W + 3 * ADDR_W + 6 + ALUOP_W;

  logic [EX_W-1:0] ex_q;
  logic [EX_W-1:0] ex_d;
  logic [EX_W-1:0] id_vec;
  logic            load_use;
  sel_e            sel;

  assign id_vec = {id_valid, id_pc_plus4, id_rs_data, id_rt_data, id_imm,
                   id_rs, id_rt, id_rd,
                   id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write,
                   id_alu_src, id_reg_dst, id_alu_op};

  assign {ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm,
          ex_rs, ex_rt, ex_rd,
          ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
          ex_alu_src, ex_reg_dst, ex_alu_op} = ex_q;

  id_ex_stage_hazard_detect #(
    .ADDR_W (ADDR_W)
  ) u_hazard (
    .ex_valid_i    (ex_valid),
    .ex_mem_read_i (ex_mem_read),
    .ex_rt_i       (ex_rt),
    .id_valid_i    (id_valid),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .load_use_o    (load_use)
  );

  // A flushed consumer does not need its load result, so no stall.
  // Driven from registered EX state, so reset drops it without a clock edge.
  assign stall = load_use & ~flush;

  assign sel = pick_sel(flush, hold, load_use);

  always_comb begin
    ex_d = ex_q;
    unique case (sel)
      SEL_FLUSH, SEL_BUBBLE: ex_d = '0;
      SEL_HOLD:              ex_d = ex_q;
      // An empty ID slot enters as a bubble whatever its control bits say.
      SEL_LOAD:              ex_d = id_valid ? id_vec : '0;
      default:               ex_d = ex_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Counters wrap naturally at 2^32; SEL_HOLD leaves both untouched.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (sel == SEL_BUBBLE) bubble_cnt_d = bubble_cnt_q + 32'd1;
    if (sel == SEL_FLUSH)  flush_cnt_d  = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Self-checking bench for id_ex_stage. Expected EX contents are pushed to a
// queue as each ID instruction is driven and popped one edge later.
// Build with ID_EX_PERF_EN defined to also check the performance counters.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc_plus4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    logic        reg_dst;
    logic [3:0]  alu_op;
  } fields_t;

  logic    clk;
  logic    rst_n;
  logic    flush;
  logic    hold;
  fields_t id_f;
  fields_t ex_f;
  fields_t exp_f;
  fields_t exp_q[$];
  int      n_cmp;
  int      n_bad;

  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write;
  logic        ex_alu_src, ex_reg_dst;
  logic [3:0]  ex_alu_op;
`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt, flush_cnt;
  logic [31:0] base_bubble;
`endif

  assign ex_f = {ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm,
                 ex_rs, ex_rt, ex_rd, ex_reg_write, ex_mem_to_reg,
                 ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_dst, ex_alu_op};

  id_ex_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_f.valid),
    .id_pc_plus4   (id_f.pc_plus4),
    .id_rs_data    (id_f.rs_data),
    .id_rt_data    (id_f.rt_data),
    .id_imm        (id_f.imm),
    .id_rs         (id_f.rs),
    .id_rt         (id_f.rt),
    .id_rd         (id_f.rd),
    .id_reg_write  (id_f.reg_write),
    .id_mem_to_reg (id_f.mem_to_reg),
    .id_mem_read   (id_f.mem_read),
    .id_mem_write  (id_f.mem_write),
    .id_alu_src    (id_f.alu_src),
    .id_reg_dst    (id_f.reg_dst),
    .id_alu_op     (id_f.alu_op),
    .flush         (flush),
    .hold          (hold),
    .stall         (stall),
    .ex_valid      (ex_valid),
    .ex_pc_plus4   (ex_pc_plus4),
    .ex_rs_data    (ex_rs_data),
    .ex_rt_data    (ex_rt_data),
    .ex_imm        (ex_imm),
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_alu_src    (ex_alu_src),
    .ex_reg_dst    (ex_reg_dst),
    .ex_alu_op     (ex_alu_op)
`ifdef ID_EX_PERF_EN
    ,
    .bubble_cnt    (bubble_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Builds a valid instruction with random operand data.
  function automatic fields_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic is_load,
                                 input logic [3:0] alu_op);
    fields_t f;
    f.valid      = 1'b1;
    f.pc_plus4   = $urandom;
    f.rs_data    = $urandom;
    f.rt_data    = $urandom;
    f.imm        = $urandom;
    f.rs         = rs;
    f.rt         = rt;
    f.rd         = rd;
    f.reg_write  = 1'b1;
    f.mem_to_reg = is_load;
    f.mem_read   = is_load;
    f.mem_write  = 1'b0;
    f.alu_src    = is_load;
    f.reg_dst    = ~is_load;
    f.alu_op     = alu_op;
    return f;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    hold  = 1'b0;
    id_f  = '0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    fields_t lw;
    rst_n = 1'b0; flush = 1'b0; hold = 1'b0; id_f = '0;
    @(posedge clk); #1;
    n_cmp++;
    if (ex_f !== '0) begin
      n_bad++; $display("FAIL reset_init: ex=%h required 0", ex_f);
    end
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++; $display("FAIL reset_init_stall: stall=%b required 0", stall);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Put a load with reg_write=1 into EX, then present a dependent use.
    lw = mk(5'd1, 5'd8, 5'd0, 1'b1, 4'h2);
    id_f = lw; exp_q.push_back(lw);
    @(posedge clk); #1;
    exp_f = exp_q.pop_front(); n_cmp++;
    if (ex_f !== exp_f) begin
      n_bad++; $display("FAIL reset_lw_load: ex=%h required %h", ex_f, exp_f);
    end
    id_f = mk(5'd8, 5'd2, 5'd9, 1'b0, 4'h2);
    #1; n_cmp++;
    if (stall !== 1'b1) begin
      n_bad++; $display("FAIL reset_pre_stall: stall=%b required 1", stall);
    end
    // Reset asserted between clock edges must clear everything at once.
    #2 rst_n = 1'b0;
    #1; n_cmp++;
    if (ex_f !== '0) begin
      n_bad++; $display("FAIL reset_async: ex=%h required 0", ex_f);
    end
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++; $display("FAIL reset_async_stall: stall=%b required 0", stall);
    end
    $display("reset: async clear checked");
    apply_reset();
  endtask

  task automatic test_pass_through();
    id_f = mk(5'd3, 5'd4, 5'd5, 1'b0, 4'h2);
    exp_q.push_back(id_f);
    @(posedge clk); #1;
    exp_f = exp_q.pop_front(); n_cmp++;
    if (ex_f !== exp_f) begin
      n_bad++; $display("FAIL pass_through: ex=%h required %h", ex_f, exp_f);
    end
    n_cmp++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd5 || ex_alu_op !== 4'h2) begin
      n_bad++; $display("FAIL pass_fields: valid=%b rd=%0d op=%h required 1/5/2", ex_valid, ex_rd, ex_alu_op);
    end
    $display("pass_through: rs=%0d rt=%0d rd=%0d", ex_rs, ex_rt, ex_rd);
  endtask

  task automatic test_load_use();
    fields_t add;
`ifdef ID_EX_PERF_EN
    base_bubble = bubble_cnt;
`endif
    id_f = mk(5'd1, 5'd8, 5'd0, 1'b1, 4'h2);
    exp_q.push_back(id_f);
    @(posedge clk); #1;
    exp_f = exp_q.pop_front(); n_cmp++;
    if (ex_f !== exp_f) begin
      n_bad++; $display("FAIL lu_lw: ex=%h required %h", ex_f, exp_f);
    end
    add = mk(5'd8, 5'd2, 5'd9, 1'b0, 4'h2);
    id_f = add;
    #1; n_cmp++;
    if (stall !== 1'b1) begin
      n_bad++; $display("FAIL lu_stall: stall=%b required 1", stall);
    end
    exp_q.push_back('0);
    @(posedge clk); #1;
    exp_f = exp_q.pop_front(); n_cmp++;
    if (ex_f !== exp_f) begin
      n_bad++; $display("FAIL lu_bubble: ex=%h required %h", ex_f, exp_f);
    end
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++; $display("FAIL lu_stall_clear: stall=%b required 0", stall);
    end
    exp_q.push_back(add);
    @(posedge clk); #1;
    exp_f = exp_q.pop_front(); n_cmp++;
    if (ex_f !== exp_f) begin
      n_bad++; $display("FAIL lu_add: ex=%h required %h", ex_f, exp_f);
    end
`ifdef ID_EX_PERF_EN
    n_cmp++;
    if (bubble_cnt !== base_bubble + 32'd1) begin
      n_bad++; $display("FAIL lu_bubble_cnt: cnt=%0d required %0d", bubble_cnt, base_bubble + 32'd1);
    end
`endif
    $display("load_use: one bubble then add rd=%0d", ex_rd);
  endtask

  task automatic test_zero_reg();
    id_f = mk(5'd1, 5'd0, 5'd0, 1'b1, 4'h2);
    exp_q.push_back(id_f);
    @(posedge clk); #1;
    exp_f = exp_q.pop_front(); n_cmp++;
    if (ex_f !== exp_f) begin
      n_bad++; $display("FAIL zero_lw: ex=%h required %h", ex_f, exp_f);
    end
    id_f = mk(5'd0, 5'd0, 5'd7, 1'b0, 4'h1);
    #1; n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++; $display("FAIL zero_stall: stall=%b required 0", stall);
    end
    exp_q.push_back(id_f);
    @(posedge clk); #1;
    exp_f = exp_q.pop_front(); n_cmp++;
    if (ex_f !== exp_f) begin
      n_bad++; $display("FAIL zero_no_bubble: ex=%h required %h", ex_f, exp_f);
    end
    $display("zero_reg: rd=%0d entered without bubble", ex_rd);
  endtask

  task automatic test_flush_vs_load_use();
    apply_reset();
    id_f = mk(5'd1, 5'd8, 5'd0, 1'b1, 4'h2);
    exp_q.push_back(id_f);
    @(posedge clk); #1;
    exp_f = exp_q.pop_front(); n_cmp++;
    if (ex_f !== exp_f) begin
      n_bad++; $display("FAIL flush_lw: ex=%h required %h", ex_f, exp_f);
    end
    id_f = mk(5'd8, 5'd2, 5'd9, 1'b0, 4'h2);
    flush = 1'b1;
    #1; n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++; $display("FAIL flush_stall: stall=%b required 0", stall);
    end
    exp_q.push_back('0);
    @(posedge clk); #1;
    flush = 1'b0;
    exp_f = exp_q.pop_front(); n_cmp++;
    if (ex_f !== exp_f) begin
      n_bad++; $display("FAIL flush_bubble: ex=%h required %h", ex_f, exp_f);
    end
`ifdef ID_EX_PERF_EN
    n_cmp++;
    if (flush_cnt !== 32'd1 || bubble_cnt !== 32'd0) begin
      n_bad++; $display("FAIL flush_cnts: flush=%0d bubble=%0d required 1/0", flush_cnt, bubble_cnt);
    end
`endif
    $display("flush_vs_load_use: bubble loaded, stall suppressed");
  endtask

  task automatic test_hold();
    fields_t a;
    fields_t add;
    a = mk(5'd10, 5'd11, 5'd12, 1'b0, 4'h1);
    id_f = a; exp_q.push_back(a);
    @(posedge clk); #1;
    exp_f = exp_q.pop_front(); n_cmp++;
    if (ex_f !== exp_f) begin
      n_bad++; $display("FAIL hold_load: ex=%h required %h", ex_f, exp_f);
    end
    for (int i = 0; i < 3; i++) begin
      id_f = mk(5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)), 5'(i + 20), 1'($urandom_range(0, 1)), 4'h6);
      hold = 1'b1;
      exp_q.push_back(a);
      @(posedge clk); #1;
      exp_f = exp_q.pop_front(); n_cmp++;
      if (ex_f !== exp_f) begin
        n_bad++; $display("FAIL hold_frozen_%0d: ex=%h required %h", i, ex_f, exp_f);
      end
    end
    hold = 1'b0;
    exp_q.push_back(id_f);
    @(posedge clk); #1;
    exp_f = exp_q.pop_front(); n_cmp++;
    if (ex_f !== exp_f) begin
      n_bad++; $display("FAIL hold_release: ex=%h required %h", ex_f, exp_f);
    end
    // Hold over a load-use: stall still reported, no bubble until release.
    a = mk(5'd1, 5'd8, 5'd0, 1'b1, 4'h2);
    id_f = a; exp_q.push_back(a);
    @(posedge clk); #1;
    exp_f = exp_q.pop_front();
`ifdef ID_EX_PERF_EN
    base_bubble = bubble_cnt;
`endif
    add = mk(5'd3, 5'd8, 5'd9, 1'b0, 4'h2);
    id_f = add; hold = 1'b1;
    #1; n_cmp++;
    if (stall !== 1'b1) begin
      n_bad++; $display("FAIL hold_lu_stall: stall=%b required 1", stall);
    end
    exp_q.push_back(a);
    @(posedge clk); #1;
    exp_f = exp_q.pop_front(); n_cmp++;
    if (ex_f !== exp_f) begin
      n_bad++; $display("FAIL hold_lu_frozen: ex=%h required %h", ex_f, exp_f);
    end
    hold = 1'b0;
    exp_q.push_back('0);
    exp_q.push_back(add);
    @(posedge clk); #1;
    exp_f = exp_q.pop_front(); n_cmp++;
    if (ex_f !== exp_f) begin
      n_bad++; $display("FAIL hold_lu_bubble: ex=%h required %h", ex_f, exp_f);
    end
    @(posedge clk); #1;
    exp_f = exp_q.pop_front(); n_cmp++;
    if (ex_f !== exp_f) begin
      n_bad++; $display("FAIL hold_lu_add: ex=%h required %h", ex_f, exp_f);
    end
`ifdef ID_EX_PERF_EN
    n_cmp++;
    if (bubble_cnt !== base_bubble + 32'd1) begin
      n_bad++; $display("FAIL hold_bubble_cnt: cnt=%0d required %0d", bubble_cnt, base_bubble + 32'd1);
    end
`endif
    $display("hold: frozen 3 cycles, load-use held then one bubble");
  endtask

  task automatic test_invalid();
    fields_t f;
    f = mk(5'd4, 5'd5, 5'd6, 1'b1, 4'h7);
    f.valid = 1'b0;
    f.mem_write = 1'b1;
    id_f = f;
    exp_q.push_back('0);
    @(posedge clk); #1;
    exp_f = exp_q.pop_front(); n_cmp++;
    if (ex_f !== exp_f) begin
      n_bad++; $display("FAIL invalid_bubble: ex=%h required %h", ex_f, exp_f);
    end
    $display("invalid: id_valid=0 entered as bubble");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      id_f = mk(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(1, 31)), 1'b0, 4'($urandom_range(0, 15)));
      exp_q.push_back(id_f);
      @(posedge clk); #1;
      exp_f = exp_q.pop_front(); n_cmp++;
      if (ex_f !== exp_f) begin
        n_bad++; $display("FAIL b2b_%0d: ex=%h required %h", i, ex_f, exp_f);
      end
      $display("b2b %0d: rd=%0d op=%h", i, ex_rd, ex_alu_op);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_pass_through();
    test_load_use();
    test_zero_reg();
    test_flush_vs_load_use();
    test_hold();
    test_invalid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
